// File: rtl/fp_div_arbiter.sv
// Two-requester round-robin front end that time-shares one combinational
// single-precision divider; operands are held for DIV_LAT cycles before capture.

module fp_div_unit (
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] S,
    output logic        overf,
    output logic        underf
);
    logic        sa, sb, sq;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [49:0] num, den;
    logic [26:0] quo;
    logic        rem_nz;
    logic [23:0] mant;
    logic        guard, sticky;
    logic [24:0] rnd;
    logic [22:0] frac;
    logic [9:0]  e_raw, e_fin;

    assign {sa, ea, fa} = A;
    assign {sb, eb, fb} = B;
    assign sq     = sa ^ sb;
    assign a_nan  = (ea == 8'hff) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hff) && (fb != 23'd0);
    assign a_inf  = (ea == 8'hff) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hff) && (fb == 23'd0);
    // Subnormal operands are flushed to zero.
    assign a_zero = (ea == 8'd0);
    assign b_zero = (eb == 8'd0);

    // Quotient of the 24-bit significands lies in (2^25, 2^27).
    assign num    = {1'b1, fa, 26'd0};
    assign den    = {26'd0, 1'b1, fb};
    assign quo    = 27'(num / den);
    assign rem_nz = (num % den) != 50'd0;

    assign mant   = quo[26] ? quo[26:3] : quo[25:2];
    assign guard  = quo[26] ? quo[2] : quo[1];
    assign sticky = (quo[26] ? |quo[1:0] : quo[0]) | rem_nz;
    assign rnd    = {1'b0, mant} + {24'd0, guard & (sticky | mant[0])};
    assign frac   = rnd[24] ? rnd[23:1] : rnd[22:0];
    assign e_raw  = {2'b00, ea} - {2'b00, eb} + 10'd127 - {9'd0, ~quo[26]};
    assign e_fin  = e_raw + {9'd0, rnd[24]};

    always_comb begin
        S      = 32'd0;
        overf  = 1'b0;
        underf = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
            S = 32'h7fc0_0000;
        end else if (a_inf || b_zero) begin
            S = {sq, 8'hff, 23'd0};
        end else if (a_zero || b_inf) begin
            S = {sq, 31'd0};
        end else if ($signed(e_fin) >= 10'sd255) begin
            S     = {sq, 8'hff, 23'd0};
            overf = 1'b1;
        end else if ($signed(e_fin) <= 10'sd0) begin
            S      = {sq, 31'd0};
            underf = 1'b1;
        end else begin
            S = {sq, e_fin[7:0], frac};
        end
    end
endmodule

module fp_div_arbiter #(
    parameter int unsigned DIV_LAT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_s,
    output logic        res_overf,
    output logic        res_underf,
    output logic        res_id,
    output logic        busy,
    output logic [7:0]  done_cnt
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StExec = 2'd1;
    localparam logic [1:0] StDone = 2'd2;
    localparam logic [3:0] LatCnt = 4'(DIV_LAT);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic        id_q, id_d;
    logic        last_q, last_d;
    logic [31:0] s_q, s_d;
    logic        ov_q, ov_d, un_q, un_d;
    logic [7:0]  done_cnt_q, done_cnt_d;
    logic        gnt0, gnt1, idle;
    logic [31:0] div_s;
    logic        div_ov, div_un;

    fp_div_unit u_div (
        .A      (op_a_q),
        .B      (op_b_q),
        .S      (div_s),
        .overf  (div_ov),
        .underf (div_un)
    );

    // last_q is the index granted most recently; it resets to 1 so requester 0 wins first.
    assign gnt0 = req0_valid & (~req1_valid | last_q);
    assign gnt1 = req1_valid & (~req0_valid | ~last_q);
    assign idle = (state_q == StIdle);

    assign req0_ready = rst_n & idle & gnt0;
    assign req1_ready = rst_n & idle & gnt1;
    assign res_valid  = (state_q == StDone);
    assign busy       = ~idle;
    assign res_s      = s_q;
    assign res_overf  = ov_q;
    assign res_underf = un_q;
    assign res_id     = id_q;
    assign done_cnt   = done_cnt_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        id_d       = id_q;
        last_d     = last_q;
        s_d        = s_q;
        ov_d       = ov_q;
        un_d       = un_q;
        done_cnt_d = done_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req0_valid || req1_valid) begin
                    state_d = StExec;
                    cnt_d   = LatCnt;
                    id_d    = gnt1;
                    last_d  = gnt1;
                    op_a_d  = gnt1 ? req1_a : req0_a;
                    op_b_d  = gnt1 ? req1_b : req0_b;
                end
            end
            StExec: begin
                if (cnt_q == 4'd1) begin
                    state_d = StDone;
                    cnt_d   = 4'd0;
                    s_d     = div_s;
                    ov_d    = div_ov;
                    un_d    = div_un;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                if (res_ready) begin
                    state_d    = StIdle;
                    done_cnt_d = done_cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            op_a_q     <= 32'd0;
            op_b_q     <= 32'd0;
            id_q       <= 1'b0;
            last_q     <= 1'b1;
            s_q        <= 32'd0;
            ov_q       <= 1'b0;
            un_q       <= 1'b0;
            done_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            id_q       <= id_d;
            last_q     <= last_d;
            s_q        <= s_d;
            ov_q       <= ov_d;
            un_q       <= un_d;
            done_cnt_q <= done_cnt_d;
        end
    end
endmodule

// File: tb/tb_fp_div_arbiter.sv
// Directed bench for fp_div_arbiter with DIV_LAT=2 and hand-computed quotients.

module tb_fp_div_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        res_valid, res_ready;
    logic [31:0] res_s;
    logic        res_overf, res_underf, res_id, busy;
    logic [7:0]  done_cnt;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    fp_div_arbiter #(.DIV_LAT(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_s      (res_s),
        .res_overf  (res_overf),
        .res_underf (res_underf),
        .res_id     (res_id),
        .busy       (busy),
        .done_cnt   (done_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_res(input string tag);
        int n = 0;
        while (!res_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq(tag, 32'(res_valid), 32'd1);
    endtask

    task automatic run_op(input logic id, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_s, input logic exp_ov, input logic exp_un);
        int n = 0;
        if (id) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            tick();
            n++;
        end
        check_eq("op_grant", 32'(id ? req1_ready : req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_res("op_valid");
        check_eq("op_s", res_s, exp_s);
        check_eq("op_id", 32'(res_id), 32'(id));
        check_eq("op_ovf", 32'(res_overf), 32'(exp_ov));
        check_eq("op_unf", 32'(res_underf), 32'(exp_un));
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] va [8];
        logic [31:0] vb [8];
        logic [31:0] vs [8];
        logic        vo [8];
        logic        vu [8];
        logic        seen;

        va = '{32'h7f000000, 32'h00800000, 32'h3f800000, 32'h7fc00000,
               32'h00000000, 32'h3f800000, 32'hff800000, 32'hc0400000};
        vb = '{32'h3f000000, 32'h7f000000, 32'h00000000, 32'h3f800000,
               32'h00000000, 32'h40400000, 32'h40000000, 32'h3fc00000};
        vs = '{32'h7f800000, 32'h00000000, 32'h7f800000, 32'h7fc00000,
               32'h7fc00000, 32'h3eaaaaab, 32'hff800000, 32'hc0000000};
        vo = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vu = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;

        // Reset values, with a request already pending.
        req0_valid = 1'b1; req0_a = 32'h43d10000; req0_b = 32'h40000000;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready0", 32'(req0_ready), 32'd0);
        check_eq("rst_valid", 32'(res_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_cnt", 32'(done_cnt), 32'd0);
        check_eq("rst_s", res_s, 32'd0);

        // Single request: handshake in cycle k, result in k+3.
        rst_n = 1'b1;
        #1;
        check_eq("t1_ready0", 32'(req0_ready), 32'd1);
        check_eq("t1_ready1", 32'(req1_ready), 32'd0);
        tick();
        check_eq("t1_k1_valid", 32'(res_valid), 32'd0);
        check_eq("t1_k1_ready", 32'(req0_ready), 32'd0);
        check_eq("t1_k1_busy", 32'(busy), 32'd1);
        req0_valid = 1'b0;
        tick();
        check_eq("t1_k2_valid", 32'(res_valid), 32'd0);
        tick();
        check_eq("t1_k3_valid", 32'(res_valid), 32'd1);
        check_eq("t1_s", res_s, 32'h43510000);
        check_eq("t1_id", 32'(res_id), 32'd0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_eq("t1_idle", 32'(busy), 32'd0);
        check_eq("t1_cnt", 32'(done_cnt), 32'd1);

        // Simultaneous requests after reset: req0 first, then req1.
        rst_n = 1'b0;
        #1;
        check_eq("t2_rst_cnt", 32'(done_cnt), 32'd0);
        req0_valid = 1'b1; req0_a = 32'h3f000000; req0_b = 32'h3e000000;
        req1_valid = 1'b1; req1_a = 32'h43d10000; req1_b = 32'h40000000;
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("t2_ready0", 32'(req0_ready), 32'd1);
        check_eq("t2_ready1", 32'(req1_ready), 32'd0);
        tick();
        wait_res("t2_valid_a");
        check_eq("t2_s_a", res_s, 32'h40800000);
        check_eq("t2_id_a", 32'(res_id), 32'd0);
        res_ready = 1'b1;
        #1;
        check_eq("t2_hs_ready0", 32'(req0_ready), 32'd0);
        check_eq("t2_hs_ready1", 32'(req1_ready), 32'd0);
        tick();
        res_ready = 1'b0;
        #1;
        check_eq("t2_rr_ready1", 32'(req1_ready), 32'd1);
        check_eq("t2_rr_ready0", 32'(req0_ready), 32'd0);
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_res("t2_valid_b");
        check_eq("t2_s_b", res_s, 32'h43510000);
        check_eq("t2_id_b", 32'(res_id), 32'd1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_eq("t2_cnt", 32'(done_cnt), 32'd2);

        // Backpressure: result held for 10 cycles with both requesters waiting.
        req1_valid = 1'b1; req1_a = 32'h3f800000; req1_b = 32'h40800000;
        #1;
        check_eq("t3_ready1", 32'(req1_ready), 32'd1);
        tick();
        req0_valid = 1'b1; req0_a = 32'h40000000; req0_b = 32'h40000000;
        wait_res("t3_valid");
        for (int i = 0; i < 10; i++) begin
            check_eq("t3_hold_valid", 32'(res_valid), 32'd1);
            check_eq("t3_hold_s", res_s, 32'h3e800000);
            check_eq("t3_hold_rdy", {30'd0, req0_ready, req1_ready}, 32'd0);
            check_eq("t3_hold_busy", 32'(busy), 32'd1);
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_eq("t3_idle_busy", 32'(busy), 32'd0);
        check_eq("t3_idle_valid", 32'(res_valid), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Operand corruption after acceptance.
        req0_valid = 1'b1; req0_a = 32'h43d10000; req0_b = 32'h40000000;
        #1;
        check_eq("t4_ready0", 32'(req0_ready), 32'd1);
        tick();
        req0_valid = 1'b0; req0_a = 32'h00000000;
        wait_res("t4_valid");
        check_eq("t4_s", res_s, 32'h43510000);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Special operands, flags and rounding.
        for (int i = 0; i < 8; i++) run_op(i[0], va[i], vb[i], vs[i], vo[i], vu[i]);

        // Reset in the middle of EXEC.
        req1_valid = 1'b1; req1_a = 32'h3f800000; req1_b = 32'h40400000;
        #1;
        tick();
        req1_valid = 1'b0;
        check_eq("t5_exec_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        req0_valid = 1'b1;
        #1;
        check_eq("t5_valid", 32'(res_valid), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_cnt", 32'(done_cnt), 32'd0);
        check_eq("t5_s", res_s, 32'd0);
        check_eq("t5_id", 32'(res_id), 32'd0);
        check_eq("t5_ready0", 32'(req0_ready), 32'd0);
        req0_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            seen |= res_valid;
            tick();
        end
        check_eq("t5_no_valid", 32'(seen), 32'd0);

        // done_cnt wraps after 256 completions.
        for (int i = 0; i < 255; i++) run_op(1'b0, 32'h3f800000, 32'h3f800000, 32'h3f800000,
                                             1'b0, 1'b0);
        check_eq("t6_cnt255", 32'(done_cnt), 32'd255);
        run_op(1'b1, 32'h40400000, 32'h3fc00000, 32'h40000000, 1'b0, 1'b0);
        check_eq("t6_wrap", 32'(done_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/fp_div_arbiter.md
FP_DIV_ARBITER -- requirements
Module: fp_div_arbiter

Interface
REQ-001 SHALL have parameter DIV_LAT, default 2, meaning cycles operands are held on the shared divider before its result is captured; legal range 1..15.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports req0_valid and req1_valid, input, 1 each, requester n presents an operation.
REQ-005 SHALL have ports req0_ready and req1_ready, output, 1 each, operation of requester n accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a and req1_b, input, 32 each, IEEE-754 single-precision dividend (a) and divisor (b).
REQ-007 SHALL have port res_valid, output, 1, result available.
REQ-008 SHALL have port res_ready, input, 1, consumer takes result.
REQ-009 SHALL have port res_s, output, 32, quotient.
REQ-010 SHALL have ports res_overf and res_underf, output, 1 each, divider flags.
REQ-011 SHALL have port res_id, output, 1, index of the requester that owns the result.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port done_cnt, output, 8, count of completed results.

Function
REQ-014 SHALL instantiate exactly one combinational division unit, ports (A, B, S, overf, underf), driven only from internal operand registers.
REQ-015 SHALL implement FSM states IDLE, EXEC and DONE.
REQ-016 In IDLE with at least one reqN_valid, SHALL grant one requester, assert only its reqN_ready combinationally in that cycle, latch its a/b and id, and go to EXEC.
REQ-017 SHALL grant round-robin: if exactly one requester is valid, grant it; if both are valid, grant the requester not granted last; the pointer updates only on a grant.
REQ-018 reqN_ready SHALL be 0 in EXEC and DONE, and 0 for the non-granted requester.
REQ-019 EXEC SHALL last exactly DIV_LAT cycles, counted by a 4-bit down-counter; on the last EXEC cycle it SHALL register divider S, overf, underf into res_s, res_overf, res_underf and go to DONE.
REQ-020 Latency: with the handshake in cycle k, res_valid SHALL first be high in cycle k+DIV_LAT+1.
REQ-021 In DONE, res_valid SHALL be 1, and res_s, res_overf, res_underf and res_id SHALL stay stable until res_ready=1.
REQ-022 DONE with res_ready=1 SHALL return to IDLE, and done_cnt SHALL increment, wrapping 255 to 0.
REQ-023 A new grant SHALL NOT occur in the same cycle as the result handshake; minimum issue interval is DIV_LAT+2 cycles.
REQ-024 Operand registers SHALL NOT change outside the IDLE grant cycle, so that requester inputs changing during EXEC do not affect the result.
REQ-025 Flags and quotient SHALL be passed unmodified from the divider, including for zero, infinity and NaN operands.
REQ-026 res_valid SHALL never be asserted without a prior accepted request.

Reset
REQ-027 While rst_n=0, regardless of clock or state, SHALL force: state IDLE; req0_ready=0; req1_ready=0; res_valid=0; res_s=0; res_overf=0; res_underf=0; res_id=0; busy=0; done_cnt=0; counter=0; operand registers=0.
REQ-028 On reset the round-robin pointer SHALL be set so that requester 0 wins the first simultaneous request.
REQ-029 Reset mid-EXEC or mid-DONE SHALL discard the operation silently: no res_valid after release, and done_cnt=0.
REQ-030 The first grant SHALL be possible in the first clock edge with rst_n=1.

Verification
REQ-031 SHALL test single request, DIV_LAT=2: req0 a=43d10000, b=40000000 -> req0_ready in cycle k, res_valid in cycle k+3, res_s=43510000, res_id=0, done_cnt=1.
REQ-032 SHALL test simultaneous requests after reset: req0 3f000000/3e000000 and req1 43d10000/40000000, both held valid -> req0 served first (res_s=40800000, id 0), then req1 (res_s=43510000, id 1).
REQ-033 SHALL test backpressure: res_ready=0 for 10 cycles in DONE -> res_valid and res_s stable, both readies 0, busy=1; then res_ready=1 -> IDLE next cycle.
REQ-034 SHALL test operand corruption: change req0_a to 00000000 after acceptance -> result still equals the latched operation.
REQ-035 SHALL test reset mid-EXEC: rst_n pulsed low in EXEC -> all outputs at their reset values immediately, and no res_valid afterwards until a new request.
REQ-036 SHALL test wrap: 256 completed operations -> done_cnt returns to 0.
